sign_flag_monitor: RTL and testbench
====================================

Name: sign_flag_monitor

Overview:
- Sits downstream of the 16-bit sign classifier and consumes its positive_flag/negative_flag pair each cycle.
- Checks that the two flags are never high together (mutex rule) and keeps running statistics of the sign classes.
- Tracks run length and class changes, and exposes a request/acknowledge snapshot port for the host/debug reader.
- This is the consumer end of the classifier's flag interface.

Parameters:
- CNT_W, 16, width of the positive/negative/zero class counters (saturating).
- RUN_W, 8, width of the current-run-length counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  flag pair is valid this cycle.
- positive_flag  input  1  classifier positive indication.
- negative_flag  input  1  classifier negative indication.
- clear  input  1  synchronous clear of all statistics and the error flag.
- snap_req  input  1  snapshot request, sampled each cycle.
- snap_ack  output  1  one-cycle pulse: snapshot outputs updated.
- snap_pos  output  CNT_W  snapshot of the positive count.
- snap_neg  output  CNT_W  snapshot of the negative count.
- snap_zero  output  CNT_W  snapshot of the zero count (both flags low).
- run_len  output  RUN_W  live length of the current same-class run.
- cur_class  output  2  live class: 00 IDLE, 01 POS, 10 NEG, 11 ZERO.
- sign_change  output  1  one-cycle pulse on a class change.
- mutex_err  output  1  sticky: both flags were seen high on a valid cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters, snapshots and run_len go to 0.
  - cur_class goes to IDLE; snap_ack, sign_change and mutex_err go to 0.
  - Deassertion is synchronous to clk.
- All outputs are registered. The effect of a valid sample is visible the cycle after it is sampled (latency 1).
- Classification of a valid sample (in_valid=1):
  - 10 (positive=1, negative=0) gives POS.
  - 01 gives NEG.
  - 00 gives ZERO.
  - 11 is illegal.
- Legal sample:
  - The matching class counter increments, saturating at all-ones.
  - Same class as cur_class: run_len increments, saturating at 2^RUN_W-1.
  - Different class: run_len loads 1 and cur_class updates.
  - sign_change pulses only if the previous cur_class was not IDLE. The first sample after reset or clear gives run_len=1 and no pulse.
- Illegal sample (11):
  - mutex_err is set and stays set.
  - No counter changes; cur_class and run_len hold; no sign_change pulse.
- in_valid=0: nothing changes; the flag inputs are ignored.
- State machine on cur_class: IDLE, POS, NEG, ZERO.
  - IDLE leaves only on a legal valid sample.
  - Any non-IDLE state moves to the class of the next legal sample.
  - clear forces IDLE from every state.
- clear:
  - Next cycle: counters=0, run_len=0, cur_class=IDLE, mutex_err=0.
  - A sample in the same cycle as clear is dropped.
  - Snapshot registers are not cleared by clear.
- Snapshot:
  - snap_req=1 at edge N loads snap_* with the counter values as held before edge N. The sample taken at edge N is excluded.
  - snap_ack=1 in the cycle after edge N, for exactly one cycle.
  - Back-to-back requests give back-to-back acks, each carrying fresh values.
  - snap_req together with clear captures the pre-clear values.
- Reset mid-run: all state is lost immediately. Any pending ack is cancelled.

Decomposition:
- Shared package sign_pkg holds:
  - class_t encoding: IDLE=2'b00, POS=2'b01, NEG=2'b10, ZERO=2'b11.
  - Default widths CNT_W_DEF=16 and RUN_W_DEF=8.
- One natural sub-module, sat_counter (parameter W; inputs inc, load1, clr): instanced three times for the class counters and once for run_len.

Test Plan:
- Reset then 3 POS, 2 NEG, 1 ZERO samples:
  - After the last sample, run_len=1, cur_class=ZERO.
  - sign_change pulses twice (POS to NEG, NEG to ZERO).
  - snap_req then gives snap_pos=3, snap_neg=2, snap_zero=1, with snap_ack pulsed one cycle after the request.
- Flags 11 with in_valid=1 after 2 POS samples:
  - mutex_err=1 and stays 1.
  - Counters unchanged, run_len=2, cur_class=POS.
  - A following POS sample gives run_len=3.
- RUN_W=8 with 300 consecutive NEG samples: run_len saturates at 255. With CNT_W=4 and 20 POS samples, snap_pos=15.
- Flag toggling with in_valid=0 over 10 cycles: no counter, run or class change, and no pulses.
- clear asserted together with a POS sample after mutex_err was set:
  - Next cycle: all counters 0, cur_class=IDLE, mutex_err=0.
  - The next POS sample gives run_len=1 with no sign_change.
- rst_n pulsed low mid-stream for less than 1 clk period: all outputs read 0 immediately. The next snap_req gives snapshots of 0.

Source files
------------

// File: rtl/sign_pkg.sv
// Shared definitions for the sign-flag monitor: class encoding and default widths.
package sign_pkg;

  typedef logic [1:0] class_t;

  localparam class_t CLS_IDLE = 2'b00;
  localparam class_t CLS_POS  = 2'b01;
  localparam class_t CLS_NEG  = 2'b10;
  localparam class_t CLS_ZERO = 2'b11;

  localparam int CNT_W_DEF = 16;
  localparam int RUN_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  // clear wins over load, load wins over increment; increment sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (load1) begin
      q <= ONE_VAL;
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + ONE_VAL;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/sign_flag_monitor.sv
// Consumer of the classifier flag pair: mutex check, class statistics,
// run tracking and a request/ack snapshot port.
module sign_flag_monitor
  import sign_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             positive_flag,
  input  logic             negative_flag,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] snap_pos,
  output logic [CNT_W-1:0] snap_neg,
  output logic [CNT_W-1:0] snap_zero,
  output logic [RUN_W-1:0] run_len,
  output logic [1:0]       cur_class,
  output logic             sign_change,
  output logic             mutex_err
);

  logic             both_s;
  logic             legal_s;
  logic             illegal_s;
  class_t           cls_s;
  class_t           next_class_s;
  logic [CNT_W-1:0] pos_cnt_r;
  logic [CNT_W-1:0] neg_cnt_r;
  logic [CNT_W-1:0] zero_cnt_r;

  // a sample arriving with clear is dropped, whether legal or not
  assign both_s    = positive_flag & negative_flag;
  assign legal_s   = in_valid & ~both_s & ~clear;
  assign illegal_s = in_valid & both_s & ~clear;

  // decode the flag pair into a class
  always_comb begin
    cls_s = CLS_ZERO;
    case ({positive_flag, negative_flag})
      2'b10:   cls_s = CLS_POS;
      2'b01:   cls_s = CLS_NEG;
      2'b00:   cls_s = CLS_ZERO;
      default: cls_s = CLS_ZERO;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_pos_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load1(1'b0),
    .inc(legal_s && (cls_s == CLS_POS)), .q(pos_cnt_r)
  );

  sat_counter #(.W(CNT_W)) u_neg_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load1(1'b0),
    .inc(legal_s && (cls_s == CLS_NEG)), .q(neg_cnt_r)
  );

  sat_counter #(.W(CNT_W)) u_zero_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load1(1'b0),
    .inc(legal_s && (cls_s == CLS_ZERO)), .q(zero_cnt_r)
  );

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .load1(legal_s && (cls_s != cur_class)),
    .inc(legal_s && (cls_s == cur_class)), .q(run_len)
  );

  // class state machine: only a legal sample moves it, clear returns to IDLE
  always_comb begin
    next_class_s = cur_class;
    case (cur_class)
      CLS_IDLE, CLS_POS, CLS_NEG, CLS_ZERO: begin
        if (clear) begin
          next_class_s = CLS_IDLE;
        end else if (legal_s) begin
          next_class_s = cls_s;
        end else begin
          next_class_s = cur_class;
        end
      end
      default: next_class_s = CLS_IDLE;
    endcase
  end

  // class register and change pulse; leaving IDLE is not a change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_class   <= CLS_IDLE;
      sign_change <= 1'b0;
    end else begin
      cur_class   <= next_class_s;
      sign_change <= legal_s && (cur_class != CLS_IDLE) && (cls_s != cur_class);
    end
  end

  // sticky mutex violation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mutex_err <= 1'b0;
    end else if (clear) begin
      mutex_err <= 1'b0;
    end else if (illegal_s) begin
      mutex_err <= 1'b1;
    end else begin
      mutex_err <= mutex_err;
    end
  end

  // snapshot captures counters as held before this edge, so it sees pre-clear values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ack  <= 1'b0;
      snap_pos  <= {CNT_W{1'b0}};
      snap_neg  <= {CNT_W{1'b0}};
      snap_zero <= {CNT_W{1'b0}};
    end else if (snap_req) begin
      snap_ack  <= 1'b1;
      snap_pos  <= pos_cnt_r;
      snap_neg  <= neg_cnt_r;
      snap_zero <= zero_cnt_r;
    end else begin
      snap_ack  <= 1'b0;
      snap_pos  <= snap_pos;
      snap_neg  <= snap_neg;
      snap_zero <= snap_zero;
    end
  end

endmodule

// File: tb/tb_sign_flag_monitor.sv
// Directed bench with a behavioural model feeding an expectation queue.
module tb_sign_flag_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        positive_flag = 1'b0;
  logic        negative_flag = 1'b0;
  logic        clear = 1'b0;
  logic        snap_req = 1'b0;

  logic        snap_ack;
  logic [15:0] snap_pos, snap_neg, snap_zero;
  logic [7:0]  run_len;
  logic [1:0]  cur_class;
  logic        sign_change, mutex_err;

  logic        s_ack;
  logic [3:0]  s_pos, s_neg, s_zero;
  logic [7:0]  s_run;
  logic [1:0]  s_cls;
  logic        s_sc, s_err;

  int checks = 0;
  int failures = 0;
  int sc_seen = 0;

  sign_flag_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .positive_flag(positive_flag),
    .negative_flag(negative_flag), .clear(clear), .snap_req(snap_req),
    .snap_ack(snap_ack), .snap_pos(snap_pos), .snap_neg(snap_neg), .snap_zero(snap_zero),
    .run_len(run_len), .cur_class(cur_class), .sign_change(sign_change), .mutex_err(mutex_err)
  );

  sign_flag_monitor #(.CNT_W(4), .RUN_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .positive_flag(positive_flag),
    .negative_flag(negative_flag), .clear(clear), .snap_req(snap_req),
    .snap_ack(s_ack), .snap_pos(s_pos), .snap_neg(s_neg), .snap_zero(s_zero),
    .run_len(s_run), .cur_class(s_cls), .sign_change(s_sc), .mutex_err(s_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   sp, sn, sz, rl;
    logic [1:0] cc;
    logic sa, sc, me;
  } exp_t;

  exp_t exq[$];

  // model state: unbounded counts, saturated only when compared
  int   m_pos, m_neg, m_zero, m_run;
  int   m_spos, m_sneg, m_szero;
  logic [1:0] m_cls;
  logic m_sc, m_err, m_ack;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_neg = 0; m_zero = 0; m_run = 0;
    m_spos = 0; m_sneg = 0; m_szero = 0;
    m_cls = 2'b00; m_sc = 1'b0; m_err = 1'b0; m_ack = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit p, input bit n, input bit c, input bit r);
    logic [1:0] k;
    m_ack = r;
    if (r) begin
      m_spos = m_pos; m_sneg = m_neg; m_szero = m_zero;
    end
    m_sc = 1'b0;
    if (c) begin
      m_pos = 0; m_neg = 0; m_zero = 0; m_run = 0; m_cls = 2'b00; m_err = 1'b0;
    end else if (v) begin
      if (p && n) begin
        m_err = 1'b1;
      end else begin
        k = p ? 2'b01 : (n ? 2'b10 : 2'b11);
        if (k == 2'b01) m_pos++;
        else if (k == 2'b10) m_neg++;
        else m_zero++;
        if (k == m_cls) m_run++;
        else begin
          m_sc  = (m_cls != 2'b00);
          m_run = 1;
          m_cls = k;
        end
      end
    end
  endtask

  function automatic exp_t snapshot_exp();
    exp_t e;
    e.sp = m_spos; e.sn = m_sneg; e.sz = m_szero; e.rl = m_run;
    e.cc = m_cls; e.sa = m_ack; e.sc = m_sc; e.me = m_err;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = exq.pop_front();
    chk("snap_ack", {31'd0, snap_ack}, {31'd0, e.sa});
    chk("snap_pos", {16'd0, snap_pos}, sat(e.sp, 65535));
    chk("snap_neg", {16'd0, snap_neg}, sat(e.sn, 65535));
    chk("snap_zero", {16'd0, snap_zero}, sat(e.sz, 65535));
    chk("run_len", {24'd0, run_len}, sat(e.rl, 255));
    chk("cur_class", {30'd0, cur_class}, {30'd0, e.cc});
    chk("sign_change", {31'd0, sign_change}, {31'd0, e.sc});
    chk("mutex_err", {31'd0, mutex_err}, {31'd0, e.me});
    chk("snap_pos_w4", {28'd0, s_pos}, sat(e.sp, 15));
    chk("run_len_w4", {24'd0, s_run}, sat(e.rl, 255));
    if (sign_change) sc_seen++;
  endtask

  task automatic step(input bit v, input bit p, input bit n, input bit c, input bit r);
    in_valid = v; positive_flag = p; negative_flag = n; clear = c; snap_req = r;
    @(posedge clk);
    model_edge(v, p, n, c, r);
    exq.push_back(snapshot_exp());
    #1;
    compare_out();
  endtask

  task automatic check_now();
    exq.push_back(snapshot_exp());
    compare_out();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // 3 POS, 2 NEG, 1 ZERO, then snapshot
    sc_seen = 0;
    repeat (3) step(1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("seq_run_len", {24'd0, run_len}, 32'd1);
    chk("seq_class_zero", {30'd0, cur_class}, 32'd3);
    chk("seq_sign_changes", sc_seen, 32'd2);
    step(0, 0, 0, 0, 1);
    chk("seq_snap_pos", {16'd0, snap_pos}, 32'd3);
    chk("seq_snap_neg", {16'd0, snap_neg}, 32'd2);
    chk("seq_snap_zero", {16'd0, snap_zero}, 32'd1);
    chk("seq_ack", {31'd0, snap_ack}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("seq_ack_drop", {31'd0, snap_ack}, 32'd0);

    // mutex violation after 2 POS
    step(0, 0, 0, 1, 0);
    repeat (2) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("mutex_set", {31'd0, mutex_err}, 32'd1);
    chk("mutex_run_hold", {24'd0, run_len}, 32'd2);
    step(1, 1, 0, 0, 0);
    chk("mutex_run3", {24'd0, run_len}, 32'd3);
    chk("mutex_sticky", {31'd0, mutex_err}, 32'd1);

    // back-to-back snapshots carry fresh values
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);

    // clear together with a POS sample drops the sample
    step(1, 1, 0, 1, 1);
    chk("clear_class", {30'd0, cur_class}, 32'd0);
    chk("clear_err", {31'd0, mutex_err}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("post_clear_run", {24'd0, run_len}, 32'd1);
    chk("post_clear_nosc", {31'd0, sign_change}, 32'd0);

    // toggling flags with in_valid low
    for (int i = 0; i < 10; i++) step(0, i[0], i[1], 0, 0);

    // run and counter saturation
    step(0, 0, 0, 1, 0);
    repeat (300) step(1, 0, 1, 0, 0);
    chk("run_sat", {24'd0, run_len}, 32'd255);
    repeat (20) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("cnt4_sat", {28'd0, s_pos}, 32'd15);
    chk("cnt16_neg", {16'd0, snap_neg}, 32'd300);

    // mid-stream reset with an ack pending
    step(1, 1, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now();
    chk("rst_ack_cancel", {31'd0, snap_ack}, 32'd0);
    #2;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    chk("rst_snap_pos0", {16'd0, snap_pos}, 32'd0);
    step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
